alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 46 ++++
 rtl/alu_arbiter_alu.sv | 57 +++++
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Purpose: shared ALU function/branch codes, FSM encoding and request record.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_arbiter_pkg;

    localparam int XLEN = 32;

    // ALU function codes; 3'd7 is deliberately left undefined.
    localparam logic [2:0] FUNC_ADD = 3'd0;
    localparam logic [2:0] FUNC_SUB = 3'd1;
    localparam logic [2:0] FUNC_AND = 3'd2;
    localparam logic [2:0] FUNC_OR  = 3'd3;
    localparam logic [2:0] FUNC_XOR = 3'd4;
    localparam logic [2:0] FUNC_SLT = 3'd5;
    localparam logic [2:0] FUNC_SLL = 3'd6;

    // Branch types, only meaningful together with FUNC_SUB; 5..7 unused.
    localparam logic [2:0] BRANCH_NONE = 3'd0;
    localparam logic [2:0] BRANCH_EQ   = 3'd1;
    localparam logic [2:0] BRANCH_NE   = 3'd2;
    localparam logic [2:0] BRANCH_LT   = 3'd3;
    localparam logic [2:0] BRANCH_GE   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]      op;
        logic [2:0]      btype;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } req_t;

    // Pick the port to serve: the sole requester, or on a tie the one that
    // did not win last time. Only meaningful when v0 | v1.
    function automatic logic pick_port(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
            return ~last;
        end
        return v1;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purpose: combinational 32-bit ALU with branch-condition evaluation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [2:0]      btype,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res,
    output logic            bcond
);

    logic [XLEN-1:0] diff;
    logic            ovf;
    logic            lt;
    logic            eq;

    // Compare results all come from the single wrapped subtraction.
    always_comb begin
        diff = a - b;
        ovf  = (a[XLEN-1] ^ b[XLEN-1]) & (diff[XLEN-1] ^ a[XLEN-1]);
        lt   = diff[XLEN-1] ^ ovf;
        eq   = (diff == '0);
    end

    // Function select; unknown codes yield zero.
    always_comb begin
        res = '0;
        case (op)
            FUNC_ADD: res = a + b;
            FUNC_SUB: res = diff;
            FUNC_AND: res = a & b;
            FUNC_OR:  res = a | b;
            FUNC_XOR: res = a ^ b;
            FUNC_SLT: res = {{(XLEN-1){1'b0}}, lt};
            FUNC_SLL: res = a << b[4:0];
            default:  res = '0;
        endcase
    end

    // Branch condition only exists for a subtract with a recognised type.
    always_comb begin
        bcond = 1'b0;
        if (op == FUNC_SUB) begin
            case (btype)
                BRANCH_EQ: bcond = eq;
                BRANCH_NE: bcond = ~eq;
                BRANCH_LT: bcond = lt;
                BRANCH_GE: bcond = ~lt;
                default:   bcond = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: two-port arbiter sharing one ALU, one transaction in flight.
// Latency: accept in cycle N -> rsp_valid in N+2; issue interval >= 3 cycles.
// Backpressure: RESP holds until owner's rsp_ready; no request accepted meanwhile.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid_0,
    output logic            req_ready_0,
    input  logic [2:0]      req_op_0,
    input  logic [2:0]      req_btype_0,
    input  logic [XLEN-1:0] req_a_0,
    input  logic [XLEN-1:0] req_b_0,
    output logic            rsp_valid_0,
    input  logic            rsp_ready_0,
    input  logic            req_valid_1,
    output logic            req_ready_1,
    input  logic [2:0]      req_op_1,
    input  logic [2:0]      req_btype_1,
    input  logic [XLEN-1:0] req_a_1,
    input  logic [XLEN-1:0] req_b_1,
    output logic            rsp_valid_1,
    input  logic            rsp_ready_1,
    output logic [XLEN-1:0] rsp_res,
    output logic            rsp_bcond,
    output logic            busy
);

    state_t          state_q;
    state_t          state_d;
    logic            last_grant_q;
    logic            owner_q;
    req_t            req_q;
    logic            grant_port;
    logic            accept;
    logic [XLEN-1:0] alu_res;
    logic            alu_bcond;

    assign grant_port = pick_port(req_valid_0, req_valid_1, last_grant_q);
    assign busy       = (state_q != ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the handshake outputs derived from the current state.
    always_comb begin
        state_d     = state_q;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        rsp_valid_0 = 1'b0;
        rsp_valid_1 = 1'b0;
        accept      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_0 || req_valid_1) begin
                    req_ready_0 = ~grant_port;
                    req_ready_1 = grant_port;
                    accept      = 1'b1;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_0 = ~owner_q;
                rsp_valid_1 = owner_q;
                if (owner_q ? rsp_ready_1 : rsp_ready_0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the granted request and remember who won.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            req_q        <= grant_port ? req_t'{req_op_1, req_btype_1, req_a_1, req_b_1}
                                       : req_t'{req_op_0, req_btype_0, req_a_0, req_b_0};
            owner_q      <= grant_port;
            last_grant_q <= grant_port;
        end
    end

    // Latch the ALU result at the end of EXEC; it stays put through RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_res   <= '0;
            rsp_bcond <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            rsp_res   <= alu_res;
            rsp_bcond <= alu_bcond;
        end
    end

    alu_arbiter_alu u_alu (
        .op    (req_q.op),
        .btype (req_q.btype),
        .a     (req_q.a),
        .b     (req_q.b),
        .res   (alu_res),
        .bcond (alu_bcond)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid_0 = 0, req_valid_1 = 0;
    logic        req_ready_0, req_ready_1;
    logic [2:0]  req_op_0 = 0, req_op_1 = 0, req_btype_0 = 0, req_btype_1 = 0;
    logic [31:0] req_a_0 = 0, req_b_0 = 0, req_a_1 = 0, req_b_1 = 0;
    logic        rsp_valid_0, rsp_valid_1;
    logic        rsp_ready_0 = 1, rsp_ready_1 = 1;
    logic [31:0] rsp_res;
    logic        rsp_bcond;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_op_0(req_op_0),
        .req_btype_0(req_btype_0), .req_a_0(req_a_0), .req_b_0(req_b_0),
        .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_op_1(req_op_1),
        .req_btype_1(req_btype_1), .req_a_1(req_a_1), .req_b_1(req_b_1),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
        .rsp_res(rsp_res), .rsp_bcond(rsp_bcond), .busy(busy)
    );

    typedef struct {
        int          port;
        logic [2:0]  op;
        logic [2:0]  bt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        bc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour straight from the function/branch definitions.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [2:0] bt,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] r;
        logic        c;
        sa = a;
        sb = b;
        r  = 0;
        c  = 0;
        case (op)
            FUNC_ADD: r = a + b;
            FUNC_SUB: r = a - b;
            FUNC_AND: r = a & b;
            FUNC_OR:  r = a | b;
            FUNC_XOR: r = a ^ b;
            FUNC_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
            FUNC_SLL: r = a << b[4:0];
            default:  r = 0;
        endcase
        if (op == FUNC_SUB) begin
            if (bt == BRANCH_EQ) c = (a == b);
            if (bt == BRANCH_NE) c = (a != b);
            if (bt == BRANCH_LT) c = (sa < sb);
            if (bt == BRANCH_GE) c = (sa >= sb);
        end
        return {c, r};
    endfunction

    task automatic drive(input int p, input logic v, input logic [2:0] op, input logic [2:0] bt,
                         input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req_valid_0 = v; req_op_0 = op; req_btype_0 = bt; req_a_0 = a; req_b_0 = b;
        end else begin
            req_valid_1 = v; req_op_1 = op; req_btype_1 = bt; req_a_1 = a; req_b_1 = b;
        end
    endtask

    // Called just after a negedge; returns once some ready is seen (or bound expires).
    task automatic wait_grant(output logic got);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (req_ready_0 || req_ready_1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    // One full transaction with rsp_ready already high on port p.
    task automatic run_txn(input string tag, input int p, input logic [2:0] op, input logic [2:0] bt,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic ebc);
        logic got;
        @(negedge clk);
        drive(p, 1'b1, op, bt, a, b);
        #1;
        wait_grant(got);
        check({tag, " accept"}, {31'd0, got}, 32'd1);
        if (!got) begin
            drive(p, 1'b0, op, bt, a, b);
            return;
        end
        check({tag, " grant port"}, {31'd0, req_ready_1}, p);
        @(negedge clk);
        drive(p, 1'b0, op, bt, a, b);
        #1;
        check({tag, " no rsp in exec"}, {31'd0, rsp_valid_0 | rsp_valid_1}, 32'd0);
        @(negedge clk); #1;
        check({tag, " rsp_valid owner"}, {31'd0, (p == 0) ? rsp_valid_0 : rsp_valid_1}, 32'd1);
        check({tag, " rsp_valid other"}, {31'd0, (p == 0) ? rsp_valid_1 : rsp_valid_0}, 32'd0);
        check({tag, " res"}, rsp_res, er);
        check({tag, " bcond"}, {31'd0, rsp_bcond}, {31'd0, ebc});
    endtask

    vec_t vecs[$];

    initial begin
        logic got;
        logic [32:0] m;
        int p;
        logic [2:0] op, bt;
        logic [31:0] a, b;

        // ---- reset state ----
        reset_n = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        check("rst busy", {31'd0, busy}, 0);
        check("rst rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 0);
        check("rst rsp_res", rsp_res, 0);
        check("rst bcond", {31'd0, rsp_bcond}, 0);
        check("rst ready idle", {30'd0, req_ready_1, req_ready_0}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---- tie arbitration from reset: expect 0,1,0,1 ----
        @(negedge clk);
        drive(0, 1'b1, FUNC_ADD, BRANCH_NONE, 32'd1, 32'd2);
        drive(1, 1'b1, FUNC_ADD, BRANCH_NONE, 32'd10, 32'd20);
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(got);
            check($sformatf("tie%0d grant seen", k), {31'd0, got}, 1);
            check($sformatf("tie%0d exclusive", k), {31'd0, req_ready_0 & req_ready_1}, 0);
            check($sformatf("tie%0d winner", k), {31'd0, req_ready_1}, k % 2);
            @(negedge clk); #1;
            @(negedge clk); #1;
            check($sformatf("tie%0d rsp port", k), {30'd0, rsp_valid_1, rsp_valid_0},
                  (k % 2) ? 32'd2 : 32'd1);
            check($sformatf("tie%0d res", k), rsp_res, (k % 2) ? 32'd30 : 32'd3);
            if (k == 3) begin
                req_valid_0 = 0;
                req_valid_1 = 0;
            end
            @(negedge clk); #1;
        end

        // ---- back-pressure on port 0 while port 1 waits ----
        rsp_ready_0 = 0;
        drive(0, 1'b1, FUNC_SUB, BRANCH_NONE, 32'd100, 32'd1);
        #1;
        wait_grant(got);
        check("bp accept p0", {30'd0, req_ready_1, req_ready_0}, 32'd1);
        @(negedge clk);
        req_valid_0 = 0;
        drive(1, 1'b1, FUNC_ADD, BRANCH_NONE, 32'd3, 32'd4);
        #1;
        check("bp exec ready1", {31'd0, req_ready_1}, 0);
        @(negedge clk); #1;
        check("bp rsp_valid first", {31'd0, rsp_valid_0}, 1);
        check("bp res first", rsp_res, 32'd99);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check($sformatf("bp%0d rsp_valid_0", i), {31'd0, rsp_valid_0}, 1);
            check($sformatf("bp%0d rsp_valid_1", i), {31'd0, rsp_valid_1}, 0);
            check($sformatf("bp%0d res stable", i), rsp_res, 32'd99);
            check($sformatf("bp%0d ready1 held", i), {31'd0, req_ready_1}, 0);
        end
        @(negedge clk);
        rsp_ready_0 = 1;
        #1;
        check("bp hs cycle ready1", {31'd0, req_ready_1}, 0);
        @(negedge clk); #1;
        check("bp after hs ready1", {31'd0, req_ready_1}, 1);
        check("bp after hs valid0", {31'd0, rsp_valid_0}, 0);
        @(negedge clk);
        req_valid_1 = 0;
        @(negedge clk); #1;
        check("bp p1 rsp_valid", {31'd0, rsp_valid_1}, 1);
        check("bp p1 res", rsp_res, 32'd7);

        // ---- reset while in EXEC ----
        @(negedge clk);
        drive(0, 1'b1, FUNC_XOR, BRANCH_NONE, 32'hF0F0_0000, 32'h0000_0F0F);
        #1;
        wait_grant(got);
        check("rx accept", {31'd0, got}, 1);
        @(negedge clk);
        req_valid_0 = 0;
        #1;
        check("rx busy before", {31'd0, busy}, 1);
        reset_n = 0;
        #1;
        check("rx busy", {31'd0, busy}, 0);
        check("rx res", rsp_res, 0);
        check("rx rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 0);
        check("rx bcond", {31'd0, rsp_bcond}, 0);
        @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check($sformatf("rx%0d quiet", i), {29'd0, busy, rsp_valid_1, rsp_valid_0}, 0);
        end
        run_txn("rx next", 1, FUNC_ADD, BRANCH_NONE, 32'd40, 32'd2, 32'd42, 1'b0);

        // ---- directed vector table ----
        vecs.push_back('{0, FUNC_ADD, BRANCH_NONE, 32'd5, 32'd7, 32'd12, 1'b0});
        vecs.push_back('{0, FUNC_ADD, BRANCH_NONE, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0});
        vecs.push_back('{1, FUNC_SUB, BRANCH_LT, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFB, 1'b1});
        vecs.push_back('{1, FUNC_SUB, BRANCH_GE, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFB, 1'b0});
        vecs.push_back('{0, FUNC_SUB, BRANCH_EQ, 32'd9, 32'd9, 32'd0, 1'b1});
        vecs.push_back('{1, FUNC_SUB, BRANCH_NE, 32'd9, 32'd9, 32'd0, 1'b0});
        vecs.push_back('{0, FUNC_SUB, BRANCH_LT, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1});
        vecs.push_back('{1, FUNC_ADD, BRANCH_LT, 32'd1, 32'd2, 32'd3, 1'b0});
        vecs.push_back('{0, 3'd7, BRANCH_EQ, 32'd3, 32'd3, 32'd0, 1'b0});
        vecs.push_back('{1, FUNC_AND, BRANCH_NONE, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0});
        vecs.push_back('{0, FUNC_OR, BRANCH_NONE, 32'hFF00_0000, 32'h0000_00FF, 32'hFF00_00FF, 1'b0});
        vecs.push_back('{1, FUNC_XOR, BRANCH_NONE, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA, 1'b0});
        vecs.push_back('{0, FUNC_SLT, BRANCH_NONE, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0});
        vecs.push_back('{1, FUNC_SLL, BRANCH_NONE, 32'd3, 32'd4, 32'd48, 1'b0});
        vecs.push_back('{0, FUNC_SUB, 3'd6, 32'd1, 32'd1, 32'd0, 1'b0});
        foreach (vecs[i]) begin
            run_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].op, vecs[i].bt,
                    vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].bc);
        end

        // ---- randomized transactions against the reference model ----
        for (int i = 0; i < 40; i++) begin
            p  = $urandom_range(0, 1);
            op = 3'($urandom_range(0, 7));
            bt = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) - 32'd2 : $urandom;
            b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
            m  = model(op, bt, a, b);
            run_txn($sformatf("rnd%0d", i), p, op, bt, a, b, m[31:0], m[32]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
